// File: rtl/m_dm_access_if.sv
// Memory-side bus of the M-stage data-memory access unit.
// The master drives a word-aligned, byte-enabled request and holds it until
// the slave answers with bus_ack (read data valid with the ack).
interface m_dm_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/m_dm_access.sv
// M-stage data-memory access unit.
// Turns an M-stage load/store into one req/ack bus transaction, stalls the
// pipeline until the bus answers or MAX_WAIT cycles expire, and returns the
// raw aligned read word for the downstream load data processor.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned word/half
// accesses (exc_adel_o / exc_ades_o) instead of issuing them to the bus.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; a valid aligned request is accepted this cycle
// WAIT  | bus_req held, counting cycles until bus_ack or timeout
// DONE  | transaction finished; stall released, rdata_valid for loads
module m_dm_access #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_sel_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_raw_o,
  output logic        rdata_valid_o,
  output logic        bus_timeout_o,
  output logic        exc_adel_o,
  output logic        exc_ades_o,
  m_dm_access_if.master bus
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] rdata_raw_q;
  logic        rdata_valid_q;
  logic        bus_timeout_q;

  logic        is_half;
  logic        is_byte;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        misaligned;
  logic        idle_req;
  logic        accept;

  // Byte-lane enables and lane-replicated store data from width and address.
  always_comb begin
    is_half = (req_sel_i == 2'b01);
    is_byte = (req_sel_i == 2'b10);
    be_d    = 4'b1111;
    wdata_d = req_wdata_i;
    if (is_half) begin
      be_d    = req_addr_i[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{req_wdata_i[15:0]}};
    end else if (is_byte) begin
      be_d    = 4'b0001 << req_addr_i[1:0];
      wdata_d = {4{req_wdata_i[7:0]}};
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Word needs addr[1:0]==0, half needs addr[0]==0; bytes are always aligned.
  assign misaligned = (!is_half && !is_byte && (req_addr_i[1:0] != 2'b00)) ||
                      (is_half && req_addr_i[0]);
`else
  // Without checking, the low address bits below the access size are ignored.
  assign misaligned = 1'b0;
`endif

  assign idle_req   = (state_q == S_IDLE) && req_valid_i;
  assign accept     = idle_req && !misaligned;
  assign exc_adel_o = idle_req && misaligned && !req_we_i;
  assign exc_ades_o = idle_req && misaligned && req_we_i;

  // Stall rises combinationally in the accept cycle so M holds the request.
  assign stall_o = accept || (state_q == S_WAIT);

  assign rdata_raw_o   = rdata_raw_q;
  assign rdata_valid_o = rdata_valid_q;
  assign bus_timeout_o = bus_timeout_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

  // Transaction FSM with wait counter and registered bus/result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'h0;
      bus_be_q      <= 4'h0;
      bus_wdata_q   <= 32'h0;
      rdata_raw_q   <= 32'h0;
      rdata_valid_q <= 1'b0;
      bus_timeout_q <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      bus_timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= req_we_i;
            bus_addr_q  <= {req_addr_i[31:2], 2'b00};
            bus_be_q    <= be_d;
            bus_wdata_q <= wdata_d;
            cnt_q       <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // An ack arriving on the last allowed cycle still completes normally.
          if (bus.bus_ack) begin
            if (!bus_we_q) begin
              rdata_raw_q   <= bus.bus_rdata;
              rdata_valid_q <= 1'b1;
            end
            bus_req_q <= 1'b0;
            state_q   <= S_DONE;
          end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
            bus_timeout_q <= 1'b1;
            bus_req_q     <= 1'b0;
            state_q       <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          // req_valid here is the instruction just finished; never reissue it.
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
